operand_stage: RTL and testbench

OPERAND_STAGE -- requirements
Module: operand_stage

---
 rtl/operand_stage.sv | 110 +++++++++++
 tb/tb_operand_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stage.sv
// Operand fetch stage: 32 x XLEN register file with writeback forwarding and a
// single valid/ready output register carrying the ALU operand bundle.
module operand_stage #(
    parameter int XLEN   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [4:0]      rd_in,
    input  logic [1:0]      op_in,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [1:0]      op,
    output logic [4:0]      rd_out
);

    localparam int NREGS = 32;

    logic [XLEN-1:0] rf_reg [NREGS];
    logic            out_valid_reg;
    logic [1:0]      op_reg;
    logic [4:0]      rd_reg;
    logic [4:0]      src_addr     [2];
    logic [4:0]      held_idx_reg [2];
    logic [XLEN-1:0] opnd_reg     [2];
    logic            accept;
    logic            wb_live;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign wb_live  = wb_en && (wb_addr != 5'd0);

    assign src_addr[0] = rs1_addr;
    assign src_addr[1] = rs2_addr;

    // Entry 0 never sees a write enable, so it stays at its reset value of zero.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_rf
            logic wr_hit;
            assign wr_hit = (gi != 0) && wb_live && (wb_addr == 5'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rf_reg[gi] <= '0;
                end else if (wr_hit) begin
                    rf_reg[gi] <= wb_data;
                end
            end
        end
    endgenerate

    // Operand lane 0 feeds A from rs1, lane 1 feeds B from rs2; each forwards on its own.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [XLEN-1:0] rf_rd;
            logic [XLEN-1:0] capture_val;
            logic            fwd_hit;
            logic            refresh_hit;

            assign rf_rd       = rf_reg[src_addr[gi]];
            assign fwd_hit     = (BYPASS != 0) && wb_live && (wb_addr == src_addr[gi]);
            assign refresh_hit = (BYPASS != 0) && wb_live && (wb_addr == held_idx_reg[gi]);
            assign capture_val = fwd_hit ? wb_data : rf_rd;

            // While stalled, a writeback to the held source keeps the operand current.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opnd_reg[gi]     <= '0;
                    held_idx_reg[gi] <= '0;
                end else if (accept) begin
                    opnd_reg[gi]     <= capture_val;
                    held_idx_reg[gi] <= src_addr[gi];
                end else if (out_valid_reg && refresh_hit) begin
                    opnd_reg[gi]     <= wb_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            op_reg        <= 2'b00;
            rd_reg        <= 5'd0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            op_reg        <= op_in;
            rd_reg        <= rd_in;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign A         = opnd_reg[0];
    assign B         = opnd_reg[1];
    assign op        = op_reg;
    assign rd_out    = rd_reg;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: stimulus pushes expected bundles, a monitor
// pops and compares on every handshake; a BYPASS=0 twin shares the stimulus.
module tb_operand_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [4:0]  rd;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [4:0]  rd_in = '0;
    logic [1:0]  op_in = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid;
    logic [31:0] A, B;
    logic [1:0]  op;
    logic [4:0]  rd_out;

    logic        in_ready_nb, out_valid_nb;
    logic [31:0] A_nb, B_nb;
    logic [1:0]  op_nb;
    logic [4:0]  rd_nb;

    int checks = 0;
    int errors = 0;
    bundle_t exp_q[$];
    bundle_t mon_e;

    operand_stage #(.XLEN(32), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_in(rd_in), .op_in(op_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .op(op), .rd_out(rd_out)
    );

    operand_stage #(.XLEN(32), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nb),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_in(rd_in), .op_in(op_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid_nb), .out_ready(out_ready),
        .A(A_nb), .B(B_nb), .op(op_nb), .rd_out(rd_nb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2,
                         input logic [1:0] o, input logic [4:0] rd);
        in_valid = 1'b1;
        rs1_addr = r1;
        rs2_addr = r2;
        op_in    = o;
        rd_in    = rd;
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
    endtask

    // Monitor: every handshake consumes exactly one expected bundle, in order.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle actual rd=%0d A=%h required none", rd_out, A);
            end else begin
                mon_e = exp_q.pop_front();
                $display("bundle rd=%0d op=%0d A=%h B=%h", rd_out, op, A, B);
                chk("bundle_a", A, mon_e.a);
                chk("bundle_b", B, mon_e.b);
                chk("bundle_op", 32'(op), 32'(mon_e.op));
                chk("bundle_rd", 32'(rd_out), 32'(mon_e.rd));
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_a", A, 32'd0);
        chk("rst_b", B, 32'd0);
        chk("rst_op_rd", {25'd0, op, rd_out}, 32'd0);
        step();
        step();
        rst = 1'b0;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic fetch of x5/x6
        wb(5'd5, 32'h0000000A); step();
        wb(5'd6, 32'h00000003); step();
        wb_en = 1'b0;
        issue(5'd5, 5'd6, 2'b01, 5'd3);
        exp_q.push_back('{32'h0000000A, 32'h00000003, 2'b01, 5'd3});
        step();
        in_valid = 1'b0;
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_a", A, 32'h0000000A);
        step();

        // Same-cycle writeback and accept
        wb(5'd7, 32'hDEADBEEF);
        issue(5'd7, 5'd0, 2'b10, 5'd4);
        exp_q.push_back('{32'hDEADBEEF, 32'h0, 2'b10, 5'd4});
        step();
        wb_en = 1'b0;
        in_valid = 1'b0;
        chk("nobypass_a", A_nb, 32'h0);
        step();

        // x0 stays zero
        wb(5'd0, 32'hFFFFFFFF); step();
        wb_en = 1'b0;
        issue(5'd0, 5'd0, 2'b11, 5'd0);
        exp_q.push_back('{32'h0, 32'h0, 2'b11, 5'd0});
        step();
        in_valid = 1'b0;

        // rs1==rs2 forwarding, then a plain read of x7 after its write
        wb(5'd11, 32'h00000055);
        issue(5'd11, 5'd11, 2'b00, 5'd2);
        exp_q.push_back('{32'h55, 32'h55, 2'b00, 5'd2});
        step();
        wb_en = 1'b0;
        issue(5'd7, 5'd5, 2'b00, 5'd1);
        exp_q.push_back('{32'hDEADBEEF, 32'h0000000A, 2'b00, 5'd1});
        step();
        in_valid = 1'b0;
        chk("nobypass_x7_written", A_nb, 32'hDEADBEEF);
        step();

        // Stall with refresh of held rs2 and an ignored upstream request
        out_ready = 1'b0;
        issue(5'd5, 5'd9, 2'b01, 5'd9);
        exp_q.push_back('{32'h0000000A, 32'h12345678, 2'b01, 5'd9});
        step();
        issue(5'd6, 5'd6, 2'b00, 5'd31);
        wb(5'd9, 32'h12345678);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        step();
        wb_en = 1'b0;
        chk("stall_refresh_b", B, 32'h12345678);
        chk("stall_hold_rd", 32'(rd_out), 32'd9);
        chk("stall_hold_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Back-to-back issue
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin issue(5'd5, 5'd6, 2'd0, 5'd10); exp_q.push_back('{32'h0000000A, 32'h00000003, 2'd0, 5'd10}); end
                1: begin issue(5'd6, 5'd5, 2'd1, 5'd11); exp_q.push_back('{32'h00000003, 32'h0000000A, 2'd1, 5'd11}); end
                2: begin issue(5'd7, 5'd9, 2'd2, 5'd12); exp_q.push_back('{32'hDEADBEEF, 32'h12345678, 2'd2, 5'd12}); end
                default: begin issue(5'd9, 5'd7, 2'd3, 5'd13); exp_q.push_back('{32'h12345678, 32'hDEADBEEF, 2'd3, 5'd13}); end
            endcase
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        step();
        step();

        // Reset mid-stall discards the held bundle and the register file
        out_ready = 1'b0;
        issue(5'd5, 5'd6, 2'b01, 5'd8);
        step();
        in_valid = 1'b0;
        step();
        chk("pre_rst_stalled", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_a", A, 32'd0);
        step();
        rst = 1'b0;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        issue(5'd5, 5'd6, 2'b10, 5'd7);
        exp_q.push_back('{32'h0, 32'h0, 2'b10, 5'd7});
        step();
        in_valid = 1'b0;
        chk("rst_cleared_x5_nb", A_nb, 32'h0);
        step();
        step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
